// File: rtl/id_fwd_stage.sv
// Decode/forwarding stage: resolves two operands (immediate, zero register,
// bypass network or register file), stalls on a pending load result, and
// registers the decoded instruction into the ID/EX pipeline register.
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   flush           drop the ID/EX entry and any stalled instruction
//   in_valid/ready  decoded-instruction handshake
//   in_*            decoded operation, destination, conditional-write type
//   rs_/rt_*        operand read enables and addresses, imm, register-file data
//   fwd_*           bypass sources, index 0 youngest / highest priority
//   out_valid/ready ID/EX handshake, out_* registered payload
//   stall_cnt       saturating count of hazard-stall cycles
module id_fwd_stage #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned NUM_FWD = 3,
  parameter int unsigned AOP_W   = 8,
  parameter int unsigned SEL_W   = 3,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [AOP_W-1:0]           in_aluop,
  input  logic [SEL_W-1:0]           in_alusel,
  input  logic [4:0]                 in_wd,
  input  logic                       in_wreg,
  input  logic [1:0]                 in_cond,
  input  logic                       rs_read,
  input  logic                       rt_read,
  input  logic [4:0]                 rs_addr,
  input  logic [4:0]                 rt_addr,
  input  logic [DATA_W-1:0]          imm,
  input  logic [DATA_W-1:0]          rf_rs_data,
  input  logic [DATA_W-1:0]          rf_rt_data,
  input  logic [NUM_FWD-1:0]         fwd_wreg,
  input  logic [NUM_FWD-1:0]         fwd_pend,
  input  logic [NUM_FWD*5-1:0]       fwd_wd,
  input  logic [NUM_FWD*DATA_W-1:0]  fwd_wdata,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_W-1:0]          out_reg1,
  output logic [DATA_W-1:0]          out_reg2,
  output logic [AOP_W-1:0]           out_aluop,
  output logic [SEL_W-1:0]           out_alusel,
  output logic [4:0]                 out_wd,
  output logic                       out_wreg,
  output logic [CNT_W-1:0]           stall_cnt
);

  localparam int unsigned RA_W = 5;

  typedef enum logic {RUN, HAZ} state_t;

  state_t state_q, state_d;

  // Returns {pending, value}; the first matching source (lowest index) wins.
  function automatic logic [DATA_W:0] resolve(
    input logic                      rd,
    input logic [RA_W-1:0]           addr,
    input logic [DATA_W-1:0]         rf_data,
    input logic [DATA_W-1:0]         imm_v,
    input logic [NUM_FWD-1:0]        wreg,
    input logic [NUM_FWD-1:0]        pend,
    input logic [NUM_FWD*RA_W-1:0]   wd,
    input logic [NUM_FWD*DATA_W-1:0] wdata
  );
    logic            hit;
    logic [DATA_W:0] r;
    hit = 1'b0;
    r   = {1'b0, rf_data};
    if (!rd) begin
      r = {1'b0, imm_v};
    end else if (addr == '0) begin
      r = '0;
    end else begin
      for (int unsigned i = 0; i < NUM_FWD; i++) begin
        if (!hit && wreg[i] && (wd[i*RA_W +: RA_W] == addr)) begin
          hit = 1'b1;
          r   = {pend[i], wdata[i*DATA_W +: DATA_W]};
        end
      end
    end
    return r;
  endfunction

  logic [DATA_W:0]   rs_res, rt_res;
  logic [DATA_W-1:0] reg1_c, reg2_c;
  logic              hazard, xfer, wreg_c;

  assign rs_res = resolve(rs_read, rs_addr, rf_rs_data, imm, fwd_wreg, fwd_pend, fwd_wd, fwd_wdata);
  assign rt_res = resolve(rt_read, rt_addr, rf_rt_data, imm, fwd_wreg, fwd_pend, fwd_wd, fwd_wdata);
  assign reg1_c = rs_res[DATA_W-1:0];
  assign reg2_c = rt_res[DATA_W-1:0];
  assign hazard = rs_res[DATA_W] | rt_res[DATA_W];

  assign in_ready = !hazard && (!out_valid || out_ready) && !flush;
  assign xfer     = in_valid && in_ready;

  // Conditional write (MOVN/MOVZ) on the resolved second operand.
  always_comb begin
    wreg_c = in_wreg;
    case (in_cond)
      2'b01:   wreg_c = in_wreg && (reg2_c != '0);
      2'b10:   wreg_c = in_wreg && (reg2_c == '0);
      default: wreg_c = in_wreg;
    endcase
  end

  // HAZ tracks an instruction held back by a pending bypass source.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (in_valid && hazard) state_d = HAZ;
      HAZ:     if (!hazard) state_d = RUN;
      default: state_d = RUN;
    endcase
    if (flush) state_d = RUN;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= RUN;
    else      state_q <= state_d;
  end

  // One count per cycle that ends in HAZ, i.e. per cycle the instruction waits.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
    end else if ((state_d == HAZ) && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

  // ID/EX register: payload only changes on a transfer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid  <= 1'b0;
      out_reg1   <= '0;
      out_reg2   <= '0;
      out_aluop  <= '0;
      out_alusel <= '0;
      out_wd     <= '0;
      out_wreg   <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (xfer) begin
      out_valid  <= 1'b1;
      out_reg1   <= reg1_c;
      out_reg2   <= reg2_c;
      out_aluop  <= in_aluop;
      out_alusel <= in_alusel;
      out_wd     <= in_wd;
      out_wreg   <= wreg_c;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_id_fwd_stage.sv
module tb_id_fwd_stage;

  localparam int unsigned DW = 32;
  localparam int unsigned NF = 3;
  localparam int unsigned AW = 8;
  localparam int unsigned SW = 3;
  localparam int unsigned CW = 4;
  localparam int          CMAX = 15;

  logic            clk, rst, flush, in_valid, in_ready, in_wreg, rs_read, rt_read;
  logic [AW-1:0]   in_aluop, out_aluop;
  logic [SW-1:0]   in_alusel, out_alusel;
  logic [4:0]      in_wd, rs_addr, rt_addr, out_wd;
  logic [1:0]      in_cond;
  logic [DW-1:0]   imm, rf_rs_data, rf_rt_data, out_reg1, out_reg2;
  logic [NF-1:0]   fwd_wreg, fwd_pend;
  logic [NF*5-1:0] fwd_wd;
  logic [NF*DW-1:0] fwd_wdata;
  logic            out_valid, out_ready, out_wreg;
  logic [CW-1:0]   stall_cnt;

  id_fwd_stage #(.DATA_W(DW), .NUM_FWD(NF), .AOP_W(AW), .SEL_W(SW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_aluop(in_aluop), .in_alusel(in_alusel), .in_wd(in_wd), .in_wreg(in_wreg),
    .in_cond(in_cond), .rs_read(rs_read), .rt_read(rt_read), .rs_addr(rs_addr),
    .rt_addr(rt_addr), .imm(imm), .rf_rs_data(rf_rs_data), .rf_rt_data(rf_rt_data),
    .fwd_wreg(fwd_wreg), .fwd_pend(fwd_pend), .fwd_wd(fwd_wd), .fwd_wdata(fwd_wdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_reg1(out_reg1), .out_reg2(out_reg2),
    .out_aluop(out_aluop), .out_alusel(out_alusel), .out_wd(out_wd), .out_wreg(out_wreg),
    .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  typedef struct {
    logic        rs_read;
    logic [4:0]  rs_addr;
    logic        rt_read;
    logic [4:0]  rt_addr;
    logic [31:0] imm;
    logic [31:0] rf_rs;
    logic [31:0] rf_rt;
    logic [2:0]  fwreg;
    logic [14:0] fwd;
    logic [95:0] fdata;
    logic [1:0]  cond;
    logic        wreg;
    logic [31:0] e1;
    logic [31:0] e2;
    logic        ew;
  } vec_t;

  vec_t vt[8];

  // Operand as defined by the rules: later (lower-index) matches overwrite earlier ones.
  function automatic logic [32:0] ref_operand(input logic rd, input logic [4:0] a, input logic [31:0] rf);
    logic [32:0] r;
    if (!rd) return {1'b0, imm};
    if (a == 5'd0) return 33'd0;
    r = {1'b0, rf};
    for (int i = int'(NF) - 1; i >= 0; i--)
      if (fwd_wreg[i] && (fwd_wd[i*5 +: 5] == a)) r = {fwd_pend[i], fwd_wdata[i*32 +: 32]};
    return r;
  endfunction

  task automatic clear_inputs();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_aluop = '0; in_alusel = '0; in_wd = '0; in_wreg = 1'b0; in_cond = 2'b00;
    rs_read = 1'b0; rt_read = 1'b0; rs_addr = '0; rt_addr = '0;
    imm = '0; rf_rs_data = '0; rf_rt_data = '0;
    fwd_wreg = '0; fwd_pend = '0; fwd_wd = '0; fwd_wdata = '0;
  endtask

  // Reference-model state
  logic        m_valid, m_wreg, m_wait;
  logic [31:0] m_r1, m_r2;
  logic [7:0]  m_aop;
  logic [2:0]  m_sel;
  logic [4:0]  m_wd;
  int          m_cnt;

  initial begin
    logic [32:0] op1, op2;
    logic        haz, exp_rdy, exp_w;

    vt[0] = '{1'b1, 5'd5, 1'b1, 5'd6, 32'h0, 32'h1111, 32'h2222, 3'b011, {5'd0, 5'd5, 5'd5},
              {32'h0, 32'hBBBB, 32'hAAAA}, 2'b00, 1'b1, 32'hAAAA, 32'h2222, 1'b1};
    vt[1] = '{1'b1, 5'd0, 1'b0, 5'd0, 32'h77, 32'h1234, 32'h0, 3'b001, {5'd0, 5'd0, 5'd0},
              {32'h0, 32'h0, 32'hFFFF}, 2'b00, 1'b1, 32'h0, 32'h77, 1'b1};
    vt[2] = '{1'b0, 5'd0, 1'b1, 5'd9, 32'h5, 32'h0, 32'h0, 3'b000, 15'd0,
              96'h0, 2'b01, 1'b1, 32'h5, 32'h0, 1'b0};
    vt[3] = '{1'b1, 5'd9, 1'b1, 5'd9, 32'h0, 32'h100, 32'h0, 3'b010, {5'd0, 5'd9, 5'd0},
              {32'h0, 32'h3, 32'h0}, 2'b01, 1'b1, 32'h3, 32'h3, 1'b1};
    vt[4] = '{1'b1, 5'd4, 1'b0, 5'd0, 32'h0, 32'h44, 32'h0, 3'b100, {5'd4, 5'd0, 5'd4},
              {32'hC0DE, 32'h0, 32'h9}, 2'b10, 1'b1, 32'hC0DE, 32'h0, 1'b1};
    vt[5] = '{1'b1, 5'd3, 1'b1, 5'd3, 32'h0, 32'hDEAD, 32'hBEEF, 3'b000, {5'd3, 5'd3, 5'd3},
              {32'h1, 32'h2, 32'h3}, 2'b11, 1'b1, 32'hDEAD, 32'hBEEF, 1'b1};
    vt[6] = '{1'b0, 5'd0, 1'b1, 5'd12, 32'h8, 32'h0, 32'h1, 3'b000, 15'd0,
              96'h0, 2'b10, 1'b1, 32'h8, 32'h1, 1'b0};
    vt[7] = '{1'b1, 5'd31, 1'b1, 5'd30, 32'h0, 32'h31, 32'h30, 3'b111, {5'd30, 5'd31, 5'd30},
              {32'hC, 32'hB, 32'hA}, 2'b01, 1'b0, 32'hB, 32'hA, 1'b0};

    // Reset values
    rst = 1'b0;
    clear_inputs();
    #12;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_reg1", out_reg1, 0);
    check("rst_out_wreg", out_wreg, 0);
    check("rst_stall_cnt", stall_cnt, 0);
    @(negedge clk);
    rst = 1'b1;

    // Table vectors; the first one lands on the first edge after reset release
    for (int i = 0; i < 8; i++) begin
      rs_read = vt[i].rs_read; rs_addr = vt[i].rs_addr;
      rt_read = vt[i].rt_read; rt_addr = vt[i].rt_addr;
      imm = vt[i].imm; rf_rs_data = vt[i].rf_rs; rf_rt_data = vt[i].rf_rt;
      fwd_wreg = vt[i].fwreg; fwd_pend = '0; fwd_wd = vt[i].fwd; fwd_wdata = vt[i].fdata;
      in_cond = vt[i].cond; in_wreg = vt[i].wreg;
      in_wd = 5'(i + 10); in_aluop = 8'(i * 3 + 1); in_alusel = 3'(i);
      in_valid = 1'b1; out_ready = 1'b1;
      #1;
      check($sformatf("vec%0d_in_ready", i), in_ready, 1);
      @(posedge clk); #1;
      check($sformatf("vec%0d_valid", i), out_valid, 1);
      check($sformatf("vec%0d_reg1", i), out_reg1, vt[i].e1);
      check($sformatf("vec%0d_reg2", i), out_reg2, vt[i].e2);
      check($sformatf("vec%0d_wreg", i), out_wreg, vt[i].ew);
      check($sformatf("vec%0d_wd", i), out_wd, 64'(i + 10));
      check($sformatf("vec%0d_aluop", i), out_aluop, 64'(i * 3 + 1));
      check($sformatf("vec%0d_alusel", i), out_alusel, 64'(i));
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("drain_valid", out_valid, 0);

    // Two-cycle load-use stall on rt
    clear_inputs();
    in_valid = 1'b1; rt_read = 1'b1; rt_addr = 5'd7;
    fwd_wreg = 3'b001; fwd_pend = 3'b001; fwd_wd = 15'd7; fwd_wdata[31:0] = 32'h5555;
    #1;
    check("haz_c0_ready", in_ready, 0);
    @(posedge clk); #1;
    check("haz_c1_ready", in_ready, 0);
    check("haz_c1_cnt", stall_cnt, 1);
    @(posedge clk); #1;
    fwd_pend = '0;
    #1;
    check("haz_c2_ready", in_ready, 1);
    @(posedge clk); #1;
    check("haz_cnt", stall_cnt, 2);
    check("haz_valid", out_valid, 1);
    check("haz_reg2", out_reg2, 32'h5555);
    in_valid = 1'b0;

    // Backpressure with flush in the second held cycle
    clear_inputs();
    in_valid = 1'b1; imm = 32'h1234; in_wd = 5'd17; in_aluop = 8'h3C; in_wreg = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0; imm = 32'h9999; in_wd = 5'd2;
    #1;
    check("bp_c1_ready", in_ready, 0);
    @(posedge clk); #1;
    check("bp_c1_valid", out_valid, 1);
    check("bp_c1_reg1", out_reg1, 32'h1234);
    check("bp_c1_wd", out_wd, 5'd17);
    check("bp_c1_aluop", out_aluop, 8'h3C);
    flush = 1'b1;
    #1;
    check("bp_c2_ready", in_ready, 0);
    @(posedge clk); #1;
    check("bp_flush_valid", out_valid, 0);
    check("bp_flush_cnt", stall_cnt, 2);
    flush = 1'b0; in_valid = 1'b0;
    @(posedge clk); #1;
    check("bp_c3_valid", out_valid, 0);

    // Long hazard saturates the counter, then reset lands mid-stall
    clear_inputs();
    in_valid = 1'b1; imm = 32'hABCD; in_wd = 5'd9; in_aluop = 8'h11; in_alusel = 3'd5; in_wreg = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    rs_read = 1'b1; rs_addr = 5'd3; fwd_wreg = 3'b100; fwd_wd[14:10] = 5'd3; fwd_pend = 3'b100;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
    end
    check("sat_cnt", stall_cnt, CMAX);
    @(posedge clk); #1;
    check("sat_cnt_hold", stall_cnt, CMAX);
    check("sat_ready", in_ready, 0);
    check("sat_valid", out_valid, 1);
    check("sat_reg1", out_reg1, 32'hABCD);
    #2 rst = 1'b0;
    #1;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_reg1", out_reg1, 0);
    check("mid_rst_reg2", out_reg2, 0);
    check("mid_rst_aluop", out_aluop, 0);
    check("mid_rst_alusel", out_alusel, 0);
    check("mid_rst_wd", out_wd, 0);
    check("mid_rst_wreg", out_wreg, 0);
    check("mid_rst_cnt", stall_cnt, 0);
    clear_inputs();
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("post_rst_ready", in_ready, 1);

    // Randomized traffic against the reference model
    m_valid = 1'b0; m_wreg = 1'b0; m_wait = 1'b0; m_r1 = '0; m_r2 = '0;
    m_aop = '0; m_sel = '0; m_wd = '0; m_cnt = 0;
    for (int n = 0; n < 400; n++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 19) == 0);
      rs_read   = ($urandom_range(0, 4) != 0);
      rt_read   = ($urandom_range(0, 4) != 0);
      rs_addr   = 5'($urandom_range(0, 3));
      rt_addr   = 5'($urandom_range(0, 3));
      imm       = ($urandom_range(0, 3) == 0) ? 32'h0 : 32'($urandom);
      rf_rs_data = 32'($urandom);
      rf_rt_data = ($urandom_range(0, 3) == 0) ? 32'h0 : 32'($urandom);
      fwd_wreg  = 3'($urandom);
      for (int i = 0; i < int'(NF); i++) begin
        fwd_pend[i] = ($urandom_range(0, 7) == 0);
        fwd_wd[i*5 +: 5] = 5'($urandom_range(0, 3));
        fwd_wdata[i*32 +: 32] = ($urandom_range(0, 3) == 0) ? 32'h0 : 32'($urandom);
      end
      in_aluop = 8'($urandom); in_alusel = 3'($urandom); in_wd = 5'($urandom);
      in_wreg = 1'($urandom); in_cond = 2'($urandom);
      #1;
      op1 = ref_operand(rs_read, rs_addr, rf_rs_data);
      op2 = ref_operand(rt_read, rt_addr, rf_rt_data);
      haz = op1[32] | op2[32];
      exp_rdy = !haz && (!m_valid || out_ready) && !flush;
      check("rand_in_ready", in_ready, exp_rdy);
      case (in_cond)
        2'b01:   exp_w = in_wreg && (op2[31:0] != 32'h0);
        2'b10:   exp_w = in_wreg && (op2[31:0] == 32'h0);
        default: exp_w = in_wreg;
      endcase
      if (flush) begin
        m_valid = 1'b0;
      end else if (in_valid && exp_rdy) begin
        m_valid = 1'b1; m_r1 = op1[31:0]; m_r2 = op2[31:0];
        m_aop = in_aluop; m_sel = in_alusel; m_wd = in_wd; m_wreg = exp_w;
      end else if (out_ready) begin
        m_valid = 1'b0;
      end
      m_wait = !flush && haz && (in_valid || m_wait);
      if (m_wait && m_cnt < CMAX) m_cnt++;
      @(posedge clk); #1;
      check("rand_valid", out_valid, m_valid);
      check("rand_reg1", out_reg1, m_r1);
      check("rand_reg2", out_reg2, m_r2);
      check("rand_aluop", out_aluop, m_aop);
      check("rand_alusel", out_alusel, m_sel);
      check("rand_wd", out_wd, m_wd);
      check("rand_wreg", out_wreg, m_wreg);
      check("rand_cnt", stall_cnt, 64'(m_cnt));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/id_fwd_stage.md
ID_FWD_STAGE -- requirements
Module: id_fwd_stage

Interface
REQ-001 Parameter DATA_W, default 32, operand/data width.
REQ-002 Parameter NUM_FWD, default 3, forwarding sources; index 0 is youngest and has highest priority.
REQ-003 Parameter AOP_W, default 8, ALU-op width.
REQ-004 Parameter SEL_W, default 3, ALU-select width.
REQ-005 Parameter CNT_W, default 16, stall-counter width.
REQ-006 clk  in  1  sole clock; all state on rising edge.
REQ-007 rst  in  1  asynchronous, active-low reset.
REQ-008 flush  in  1  discard output register and any held instruction.
REQ-009 in_valid / in_ready  in / out  1 / 1  decoded-instruction handshake.
REQ-010 in_aluop, in_alusel  in  AOP_W, SEL_W  decoded operation.
REQ-011 in_wd, in_wreg  in  5, 1  destination register and write enable.
REQ-012 in_cond  in  2  00 unconditional, 01 write if reg2!=0 (MOVN), 10 write if reg2==0 (MOVZ), 11 reserved, treated as 00.
REQ-013 rs_read, rt_read  in  1 each  operand-read enables.
REQ-014 rs_addr, rt_addr  in  5 each  register-file read addresses.
REQ-015 imm  in  DATA_W  immediate; substituted for any operand whose read enable is 0.
REQ-016 rf_rs_data, rf_rt_data  in  DATA_W  register-file read data.
REQ-017 fwd_wreg, fwd_pend  in  NUM_FWD each  per-source write enable; result not yet available (load).
REQ-018 fwd_wd, fwd_wdata  in  NUM_FWD*5, NUM_FWD*DATA_W  packed destinations and data, source i at slice i.
REQ-019 out_valid / out_ready  out / in  1 / 1  ID/EX handshake.
REQ-020 out_reg1, out_reg2, out_aluop, out_alusel, out_wd, out_wreg  out  registered ID/EX payload.
REQ-021 stall_cnt  out  CNT_W  saturating count of hazard-stall cycles.

Function
REQ-022 Operand resolution combinational: read enable 0 -> imm; address 0 -> zero, never forwarded; else lowest index i with fwd_wreg[i] and fwd_wd[i]==address supplies fwd_wdata[i]; no match -> register-file data.
REQ-023 Hazard exists when an enabled, nonzero operand's highest-priority matching source has fwd_pend=1.
REQ-024 in_ready = !hazard && (!out_valid || out_ready) && !flush.
REQ-025 Transfer when in_valid && in_ready: payload loads output register next edge, out_valid=1; out_wreg = in_wreg gated by in_cond evaluated on resolved reg2.
REQ-026 out_ready=1, no transfer: out_valid clears next edge; out_ready=0: output register holds all fields unchanged.
REQ-027 State machine RUN/HAZ: RUN->HAZ when in_valid && hazard; HAZ->RUN when hazard clears or flush; in HAZ in_ready=0.
REQ-028 stall_cnt increments once per cycle in HAZ, saturates at all-ones, never wraps.
REQ-029 flush: next edge out_valid=0, state RUN; flush dominates simultaneous transfer; stall_cnt unaffected.
REQ-030 Latency one cycle from accepted input to out_valid; throughput one instruction per cycle without hazard.

Reset
REQ-031 rst=0 asynchronously forces out_valid=0, out_reg1=out_reg2=0, out_aluop=0, out_alusel=0, out_wd=0, out_wreg=0, stall_cnt=0, state RUN.
REQ-032 First transfer possible on first rising edge after rst deasserts; reset mid-stall discards the held instruction.

Verification
REQ-033 rs=5, fwd0 wd=5 data=0xAAAA, fwd1 wd=5 data=0xBBBB, both wreg -> out_reg1=0xAAAA next cycle.
REQ-034 rs=0, fwd0 wd=0 wreg=1 data=0xFFFF -> out_reg1=0.
REQ-035 rt=7, fwd0 wd=7 pend=1 for 2 cycles -> in_ready=0 two cycles, stall_cnt=2, then out_reg2=fwd0 data.
REQ-036 in_cond=01, resolved reg2=0, in_wreg=1 -> out_wreg=0; reg2=3 -> out_wreg=1.
REQ-037 out_ready=0 for 3 cycles with out_valid=1 -> payload stable, in_ready=0; flush in cycle 2 -> out_valid=0 next edge.
REQ-038 stall_cnt preset near all-ones via long hazard -> remains all-ones; rst=0 mid-hazard -> all outputs 0 immediately.
